// File: rtl/sram_arbiter_pkg.sv
// Shared op codes and widths for the SRAM arbiter and its clients.
// Op code values mirror the data-path defines; RAM_OP_NONE marks an idle bus.
package sram_arbiter_pkg;

   localparam int ADDR_W = 20;
   localparam int DATA_W = 32;
   localparam int OP_W   = 4;
   localparam int CNT_W  = 4;

   localparam logic [OP_W-1:0] RAM_OP_NONE = 4'b0000;
   localparam logic [OP_W-1:0] MEM_LW      = 4'b0001;
   localparam logic [OP_W-1:0] MEM_LB      = 4'b0010;
   localparam logic [OP_W-1:0] MEM_LBU     = 4'b0011;
   localparam logic [OP_W-1:0] MEM_LH      = 4'b0100;
   localparam logic [OP_W-1:0] MEM_LHU     = 4'b0101;
   localparam logic [OP_W-1:0] MEM_SW      = 4'b0110;
   localparam logic [OP_W-1:0] MEM_SH      = 4'b0111;
   localparam logic [OP_W-1:0] MEM_SB      = 4'b1000;

endpackage

// File: rtl/sram_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single SRAM controller.
// One transfer at a time: IDLE -> GNT_IF|GNT_MEM -> RELEASE -> IDLE, with alternating priority on ties.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15
)
(
   input  logic              clk50,
   input  logic              rst,

   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_done_o,

   input  logic [OP_W-1:0]   mem_op_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic              mem_done_o,

   output logic [OP_W-1:0]   ram_op_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i,
   input  logic              ram_success_i,

   output logic              busy_o,
   output logic              timeout_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_IF  = 2'd1,
      GNT_MEM = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state;
   logic              last_mem;
   logic [CNT_W-1:0]  gnt_cnt;

   logic              if_pend;
   logic              mem_pend;
   logic              pick_mem;
   logic              grant_end;
   logic [DATA_W-1:0] end_data;

   assign if_pend   = if_req_i;
   assign mem_pend  = (mem_op_i != RAM_OP_NONE);
   // MEM wins a tie unless it also won the previous grant.
   assign pick_mem  = mem_pend && (!if_pend || !last_mem);
   assign grant_end = ram_success_i || (gnt_cnt == CNT_LAST);
   assign end_data  = ram_success_i ? ram_rdata_i : '0;
   assign busy_o    = (state != IDLE);

   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_mem    <= 1'b0;
         gnt_cnt     <= '0;
         ram_op_o    <= RAM_OP_NONE;
         ram_addr_o  <= '0;
         ram_wdata_o <= '0;
         if_rdata_o  <= '0;
         mem_rdata_o <= '0;
         if_done_o   <= 1'b0;
         mem_done_o  <= 1'b0;
         timeout_o   <= 1'b0;
      end else begin
         if_done_o  <= 1'b0;
         mem_done_o <= 1'b0;
         case (state)
            IDLE: begin
               ram_op_o <= RAM_OP_NONE;
               gnt_cnt  <= '0;
               if (pick_mem) begin
                  state       <= GNT_MEM;
                  last_mem    <= 1'b1;
                  ram_op_o    <= mem_op_i;
                  ram_addr_o  <= mem_addr_i;
                  ram_wdata_o <= mem_wdata_i;
               end else if (if_pend) begin
                  state       <= GNT_IF;
                  last_mem    <= 1'b0;
                  ram_op_o    <= MEM_LW;
                  ram_addr_o  <= if_addr_i;
                  ram_wdata_o <= '0;
               end
            end
            GNT_IF, GNT_MEM: begin
               if (grant_end) begin
                  // Success and abort share this path; abort returns zero data.
                  state    <= RELEASE;
                  ram_op_o <= RAM_OP_NONE;
                  if (!ram_success_i) begin
                     timeout_o <= 1'b1;
                  end
                  if (state == GNT_IF) begin
                     if_rdata_o <= end_data;
                     if_done_o  <= 1'b1;
                  end else begin
                     mem_rdata_o <= end_data;
                     mem_done_o  <= 1'b1;
                  end
               end else begin
                  gnt_cnt <= gnt_cnt + 1'b1;
               end
            end
            RELEASE: begin
               ram_op_o <= RAM_OP_NONE;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter with a cycle-counting SRAM controller model
// and a transaction-level schedule model of arbitration, latency and data.
module tb_sram_arbiter;
   import sram_arbiter_pkg::*;

   logic        clk50 = 1'b0;
   logic        rst;
   logic        if_req_i;
   logic [19:0] if_addr_i;
   logic [31:0] if_rdata_o;
   logic        if_done_o;
   logic [3:0]  mem_op_i;
   logic [19:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic [31:0] mem_rdata_o;
   logic        mem_done_o;
   logic [3:0]  ram_op_o;
   logic [19:0] ram_addr_o;
   logic [31:0] ram_wdata_o;
   logic [31:0] ram_rdata_i;
   logic        ram_success_i;
   logic        busy_o;
   logic        timeout_o;

   sram_arbiter #(.TIMEOUT_CYCLES(15)) dut (
      .clk50         (clk50),
      .rst           (rst),
      .if_req_i      (if_req_i),
      .if_addr_i     (if_addr_i),
      .if_rdata_o    (if_rdata_o),
      .if_done_o     (if_done_o),
      .mem_op_i      (mem_op_i),
      .mem_addr_i    (mem_addr_i),
      .mem_wdata_i   (mem_wdata_i),
      .mem_rdata_o   (mem_rdata_o),
      .mem_done_o    (mem_done_o),
      .ram_op_o      (ram_op_o),
      .ram_addr_o    (ram_addr_o),
      .ram_wdata_o   (ram_wdata_o),
      .ram_rdata_i   (ram_rdata_i),
      .ram_success_i (ram_success_i),
      .busy_o        (busy_o),
      .timeout_o     (timeout_o)
   );

   always #5 clk50 = ~clk50;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Cycles the SRAM controller needs before success; 0 means it never answers.
   function automatic int op_cycles(input logic [3:0] op);
      case (op)
         MEM_LW, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU: return 3;
         MEM_SW, MEM_SH, MEM_SB:                   return 5;
         default:                                  return 0;
      endcase
   endfunction

   function automatic logic [31:0] sram_data(input logic [19:0] a);
      if (a == 20'h00010) return 32'h8C220004;
      return {a[11:0], a} ^ 32'hA5000000;
   endfunction

   // SRAM controller model: success in the last cycle of its read/write sequence.
   int   sram_cnt;
   logic sram_stall;
   always @(posedge clk50 or posedge rst) begin
      if (rst) sram_cnt <= 0;
      else if (ram_op_o != RAM_OP_NONE) sram_cnt <= sram_cnt + 1;
      else sram_cnt <= 0;
   end
   assign ram_success_i = !sram_stall && (ram_op_o != RAM_OP_NONE) &&
                          (op_cycles(ram_op_o) != 0) && (sram_cnt == op_cycles(ram_op_o) - 1);
   assign ram_rdata_i   = sram_data(ram_addr_o);

   logic [19:0] if_addr_a   [4];
   logic [3:0]  mem_op_a    [4];
   logic [19:0] mem_addr_a  [4];
   logic [31:0] mem_wdata_a [4];
   bit          model_last_mem;
   bit          model_tmo;

   // Each requester issues its transactions back to back, re-requesting in the cycle after its done.
   task automatic run_seq(input int n_if, input int n_mem, input bit stall);
      int          e_port  [8];
      logic [3:0]  e_op    [8];
      logic [19:0] e_addr  [8];
      logic [31:0] e_wdata [8];
      logic [31:0] e_rdata [8];
      int          e_start [8];
      int          e_done  [8];
      bit          e_tmo   [8];
      bit          e_chk_rd[8];
      int total, ri, rm, t, k, ii, mi, budget, raise_if, raise_mem, lat;
      bit take_mem;

      total = n_if + n_mem;
      ri = 0; rm = 0; t = 0;
      for (int j = 0; j < total; j++) begin
         take_mem = (rm < n_mem) && ((ri >= n_if) || !model_last_mem);
         if (take_mem) begin
            e_port[j] = 1; e_op[j] = mem_op_a[rm]; e_addr[j] = mem_addr_a[rm]; e_wdata[j] = mem_wdata_a[rm];
            rm++;
         end else begin
            e_port[j] = 0; e_op[j] = MEM_LW; e_addr[j] = if_addr_a[ri]; e_wdata[j] = 32'h0;
            ri++;
         end
         model_last_mem = take_mem;
         if (stall || op_cycles(e_op[j]) == 0) begin
            lat = 16; e_tmo[j] = 1'b1; e_chk_rd[j] = 1'b1; e_rdata[j] = 32'h0;
         end else begin
            lat = op_cycles(e_op[j]) + 1; e_tmo[j] = 1'b0;
            e_chk_rd[j] = (op_cycles(e_op[j]) == 3);
            e_rdata[j]  = sram_data(e_addr[j]);
         end
         e_start[j] = t;
         e_done[j]  = t + lat;
         t = t + lat + 1;
      end

      sram_stall = stall;
      ii = 0; mi = 0; k = 0; raise_if = -1; raise_mem = -1;
      if (n_if > 0) begin
         if_req_i = 1'b1; if_addr_i = if_addr_a[0];
      end
      if (n_mem > 0) begin
         mem_op_i = mem_op_a[0]; mem_addr_i = mem_addr_a[0]; mem_wdata_i = mem_wdata_a[0];
      end
      budget = t + 4;
      for (int cyc = 1; cyc <= budget && k < total; cyc++) begin
         @(posedge clk50); #1;
         chk("one_done", 32'(if_done_o & mem_done_o), 32'h0);
         if (cyc == raise_if) begin
            if_req_i = 1'b1; if_addr_i = if_addr_a[ii];
         end
         if (cyc == raise_mem) begin
            mem_op_i = mem_op_a[mi]; mem_addr_i = mem_addr_a[mi]; mem_wdata_i = mem_wdata_a[mi];
         end
         if (cyc == e_start[k] + 1) begin
            chk("gnt_op",    32'(ram_op_o),    32'(e_op[k]));
            chk("gnt_addr",  32'(ram_addr_o),  32'(e_addr[k]));
            chk("gnt_wdata", ram_wdata_o,      e_wdata[k]);
            chk("gnt_busy",  32'(busy_o),      32'h1);
            if (e_port[k] == 1) mem_addr_i = mem_addr_i ^ 20'h00010;
         end
         if (if_done_o || mem_done_o) begin
            chk("done_port",  32'(mem_done_o), 32'(e_port[k]));
            chk("done_cycle", 32'(cyc),        32'(e_done[k]));
            if (e_chk_rd[k])
               chk("rdata", (e_port[k] == 1) ? mem_rdata_o : if_rdata_o, e_rdata[k]);
            model_tmo = model_tmo | e_tmo[k];
            chk("timeout_flag", 32'(timeout_o),  32'(model_tmo));
            chk("rel_op",       32'(ram_op_o),   32'h0);
            chk("rel_addr",     32'(ram_addr_o), 32'(e_addr[k]));
            if (if_done_o) begin
               if_req_i = 1'b0; ii++;
               if (ii < n_if) raise_if = cyc + 1;
            end
            if (mem_done_o) begin
               mem_op_i = RAM_OP_NONE; mi++;
               if (mi < n_mem) raise_mem = cyc + 1;
            end
            k++;
         end
      end
      chk("seq_complete", 32'(k), 32'(total));
      if_req_i = 1'b0; mem_op_i = RAM_OP_NONE;
      @(posedge clk50); #1;
      chk("idle_busy", 32'(busy_o),   32'h0);
      chk("idle_op",   32'(ram_op_o), 32'h0);
   endtask

   task automatic reset_mid_store();
      sram_stall = 1'b0;
      mem_op_i = MEM_SB; mem_addr_i = 20'h00040; mem_wdata_i = 32'h00000012;
      @(posedge clk50); #1;
      chk("rst_pre_op", 32'(ram_op_o), 32'(MEM_SB));
      @(posedge clk50); #1;
      #2 rst = 1'b1;
      #1;
      chk("rst_busy",      32'(busy_o),      32'h0);
      chk("rst_op",        32'(ram_op_o),    32'h0);
      chk("rst_addr",      32'(ram_addr_o),  32'h0);
      chk("rst_wdata",     ram_wdata_o,      32'h0);
      chk("rst_if_rdata",  if_rdata_o,       32'h0);
      chk("rst_mem_rdata", mem_rdata_o,      32'h0);
      chk("rst_done",      32'(if_done_o | mem_done_o), 32'h0);
      chk("rst_timeout",   32'(timeout_o),   32'h0);
      mem_op_i = RAM_OP_NONE;
      #1 rst = 1'b0;
      model_last_mem = 1'b0;
      model_tmo      = 1'b0;
      repeat (3) begin
         @(posedge clk50); #1;
         chk("rst_no_done", 32'(if_done_o | mem_done_o), 32'h0);
      end
   endtask

   logic [3:0] valid_ops [8];

   initial begin
      valid_ops = '{MEM_LW, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_SW, MEM_SH, MEM_SB};
      rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0; mem_op_i = RAM_OP_NONE;
      mem_addr_i = '0; mem_wdata_i = '0; sram_stall = 1'b0;
      model_last_mem = 1'b0; model_tmo = 1'b0;
      repeat (2) @(posedge clk50);
      #1;
      chk("reset_busy",      32'(busy_o),    32'h0);
      chk("reset_op",        32'(ram_op_o),  32'h0);
      chk("reset_done",      32'(if_done_o | mem_done_o), 32'h0);
      chk("reset_timeout",   32'(timeout_o), 32'h0);
      chk("reset_if_rdata",  if_rdata_o,     32'h0);
      chk("reset_mem_rdata", mem_rdata_o,    32'h0);
      rst = 1'b0;
      @(posedge clk50); #1;

      // Simultaneous fetch and load: MEM, IF, MEM.
      if_addr_a[0] = 20'h00100;
      mem_op_a[0] = MEM_LW; mem_addr_a[0] = 20'h00200; mem_wdata_a[0] = 32'h0;
      mem_op_a[1] = MEM_LW; mem_addr_a[1] = 20'h00300; mem_wdata_a[1] = 32'h0;
      run_seq(1, 2, 1'b0);

      if_addr_a[0] = 20'h00010;
      run_seq(1, 0, 1'b0);

      mem_op_a[0] = MEM_SB; mem_addr_a[0] = 20'h00020; mem_wdata_a[0] = 32'h000000AB;
      run_seq(0, 1, 1'b0);

      mem_op_a[0] = MEM_LW; mem_addr_a[0] = 20'h00050; mem_wdata_a[0] = 32'h0;
      run_seq(0, 1, 1'b1);

      reset_mid_store();

      mem_op_a[0] = MEM_LW; mem_addr_a[0] = 20'h00060; mem_wdata_a[0] = 32'h0;
      run_seq(0, 1, 1'b0);

      for (int it = 0; it < 30; it++) begin
         int ni, nm;
         bit st;
         ni = $urandom_range(0, 2);
         nm = $urandom_range(0, 2);
         if (ni + nm == 0) nm = 1;
         st = ($urandom_range(0, 9) == 0);
         for (int j = 0; j < 4; j++) begin
            if_addr_a[j]   = 20'($urandom);
            mem_addr_a[j]  = 20'($urandom);
            mem_wdata_a[j] = $urandom;
            mem_op_a[j]    = ($urandom_range(0, 9) == 0) ? 4'hC : valid_ops[$urandom_range(0, 7)];
         end
         run_seq(ni, nm, st);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15: maximum number of cycles a grant waits for ram_success_i before it is aborted.
REQ-002 SHALL use one clock and an asynchronous, active-high reset, with ports clk50 and rst.
REQ-003 clk50  input  1  system clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 if_req_i  input  1  instruction-fetch read request; held high until if_done_o.
REQ-006 if_addr_i  input  20  fetch word address.
REQ-007 if_rdata_o  output  32  fetched word, registered.
REQ-008 if_done_o  output  1  one-cycle completion pulse for the fetch port.
REQ-009 mem_op_i  input  4  data-port op code from defines.v (MEM_LW/LB/LBU/LH/LHU/SW/SH/SB); 4'b0 means no request; held until mem_done_o.
REQ-010 mem_addr_i  input  20  data-port address.
REQ-011 mem_wdata_i  input  32  store data.
REQ-012 mem_rdata_o  output  32  load result, registered.
REQ-013 mem_done_o  output  1  one-cycle completion pulse for the data port.
REQ-014 ram_op_o  output  4  op code to the SRAM controller; 0 means idle.
REQ-015 ram_addr_o  output  20  address to the SRAM controller.
REQ-016 ram_wdata_o  output  32  store data to the SRAM controller.
REQ-017 ram_rdata_i  input  32  load data from the SRAM controller.
REQ-018 ram_success_i  input  1  completion strobe from the SRAM controller.
REQ-019 busy_o  output  1  high in any state other than IDLE.
REQ-020 timeout_o  output  1  sticky flag set when a grant is aborted.

Function
REQ-021 SHALL implement four states, IDLE, GNT_IF, GNT_MEM and RELEASE, registered on clk50.
REQ-022 IDLE SHALL drive ram_op_o=0; a pending request SHALL move the FSM to a GNT state on the next edge and latch that requester's op, address and wdata.
REQ-023 A fetch grant SHALL latch op MEM_LW.
REQ-024 Arbitration when both ports are pending SHALL alternate: MEM wins unless the previous grant was MEM; a single pending requester always wins.
REQ-025 In a GNT state, ram_op_o, ram_addr_o and ram_wdata_o SHALL equal the latched values, stable for the whole grant regardless of input changes.
REQ-026 ram_success_i=1 during a grant SHALL, on that edge: register ram_rdata_i into the granted port's rdata_o, assert that port's done_o for exactly one cycle, and move to RELEASE.
REQ-027 On a store grant, rdata_o SHALL still be updated from ram_rdata_i; the captured value is don't-care.
REQ-028 RELEASE SHALL last exactly one cycle with ram_op_o=0, forcing the SRAM controller back to idle, then go to IDLE.
REQ-029 Requests present during RELEASE SHALL be ignored; the requester drops its request in the cycle done_o is high.
REQ-030 Latency from request-sample edge to done_o SHALL be 4 cycles for loads and 6 cycles for stores, given the SRAM controller's 3-cycle read and 5-cycle write sequences; back-to-back grants are separated by RELEASE plus IDLE (2 cycles).
REQ-031 A 4-bit grant-cycle counter SHALL clear on grant entry; reaching TIMEOUT_CYCLES without success SHALL abort the grant: done_o pulses, rdata_o=0, timeout_o is set, and the FSM moves to RELEASE.
REQ-032 Unknown nonzero mem_op_i codes SHALL be passed through unchanged and resolve by timeout.
REQ-033 ram_success_i outside a GNT state SHALL be ignored.
REQ-034 timeout_o SHALL stay set until rst.

Reset
REQ-035 rst SHALL asynchronously force state IDLE, all outputs 0 and the arbitration history to "last grant = IF", so MEM wins the first tie.
REQ-036 rst asserted mid-grant SHALL abandon the transfer without a done pulse; the SRAM controller, sharing rst, also returns to idle.

Structure
REQ-037 Op codes SHALL come from defines.v, which SHALL gain `RAM_OP_NONE 4'b0000`; FSM state encodings SHALL be local parameters.
REQ-038 No sub-module is needed; the block SHALL instantiate nothing and connect directly to the sram_control ports.

Verification
REQ-039 Lone fetch at addr 0x00010 with SRAM model returning 0x8C220004 -> ram_op_o=MEM_LW, if_done_o 4 cycles after request, if_rdata_o=0x8C220004.
REQ-040 MEM_SB at 0x00020, wdata 0x000000AB -> ram_op_o=MEM_SB held for 5 cycles, mem_done_o at cycle 6, if_done_o stays low.
REQ-041 if_req_i and MEM_LW rise on the same cycle, both held -> MEM granted first, IF second, MEM again third; no cycle with two done pulses.
REQ-042 SRAM model never asserts success on a MEM_LW -> abort after 15 grant cycles, mem_done_o pulses, mem_rdata_o=0, timeout_o=1 until rst.
REQ-043 rst pulsed during cycle 2 of a store grant -> outputs all 0 immediately, no done pulse, next request served normally.
REQ-044 Requester changes mem_addr_i mid-grant from 0x00020 to 0x00030 -> ram_addr_o stays 0x00020 through RELEASE.
